alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 50 +++++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_muldiv.sv | 74 +++++++
 rtl/alu_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_seq.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: opcodes, carry select, flag bit positions, FSM states.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOT = 4'd0,
    OP_INC = 4'd1,
    OP_DEC = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_MUL = 4'd9,
    OP_DIV = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    CS_ALU  = 2'b00,
    CS_ONE  = 2'b01,
    CS_ZERO = 2'b10,
    CS_HOLD = 2'b11
  } carry_sel_e;

  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [2:0] next_flags(input logic [2:0] cur, input carry_sel_e sel,
                                            input logic c, input logic n, input logic z);
    logic [2:0] f;
    f = '0;
    unique case (sel)
      CS_ALU:  f[FLAG_C] = c;
      CS_ONE:  f[FLAG_C] = 1'b1;
      CS_ZERO: f[FLAG_C] = 1'b0;
      default: f[FLAG_C] = cur[FLAG_C];
    endcase
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between an issuing pipeline (master) and alu_seq (slave).
interface alu_seq_if #(parameter int unsigned WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       carry_sel;
  logic             flag_we;
  logic             flag_restore;
  logic [2:0]       flags_in;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;
  logic             busy;

  modport master (
    output in_valid, op, op_a, op_b, carry_sel, flag_we, flag_restore, flags_in,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, op, op_a, op_b, carry_sel, flag_we, flag_restore, flags_in,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply (shift-add) / unsigned divide (restoring), one bit per cycle.
// done_o/result_o/carry_o are combinational and valid on the cycle of the final step.
module alu_muldiv
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic               active_q, div_q, bz_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q, mcand_q, prod_n;
  logic [WIDTH-1:0]   mplr_q, dvs_q, rem_q, quo_q, rem_n, quo_n, diff;
  logic [WIDTH:0]     trial;
  logic               fits;

  always_comb begin
    prod_n = prod_q + (mplr_q[0] ? mcand_q : '0);
    trial  = {rem_q, quo_q[WIDTH-1]};
    fits   = trial >= {1'b0, dvs_q};
    // when fits, the true difference is below 2^WIDTH so the truncated subtract is exact
    diff   = trial[WIDTH-1:0] - dvs_q;
    rem_n  = fits ? diff : trial[WIDTH-1:0];
    quo_n  = {quo_q[WIDTH-2:0], fits};
    done_o   = active_q && (cnt_q == CW'(WIDTH - 1));
    result_o = div_q ? quo_n : prod_n[WIDTH-1:0];
    carry_o  = div_q ? bz_q : |prod_n[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      div_q    <= 1'b0;
      bz_q     <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      div_q    <= (op_i == OP_DIV);
      bz_q     <= (b_i == '0);
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplr_q   <= b_i;
      dvs_q    <= b_i;
      rem_q    <= '0;
      quo_q    <= a_i;
    end else if (active_q) begin
      active_q <= ~done_o;
      cnt_q    <= done_o ? '0 : cnt_q + 1'b1;
      prod_q   <= prod_n;
      mcand_q  <= mcand_q << 1;
      mplr_q   <= mplr_q >> 1;
      rem_q    <= rem_n;
      quo_q    <= quo_n;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with registered result and {C,N,Z} flag register.
// Define ALU_SEQ_MULDIV_EN to add iterative MUL/DIV; otherwise opcodes 9/10 pass op_b.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SH_W  = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  logic [WIDTH-1:0] result_q, result_d, alu_res;
  logic             out_valid_q, out_valid_d, alu_c;
  logic [2:0]       flags_q, flags_d;
  logic             in_ready, busy, accept, sc_accept;
  logic [SH_W-1:0]  sh_amt;
  logic [WIDTH:0]   arith, shl_w, shr_w;

  assign sh_amt = bus.op_b[SH_W-1:0];
  assign accept = bus.in_valid & in_ready;

  always_comb begin
    alu_res = bus.op_b;
    alu_c   = 1'b0;
    arith   = '0;
    // one guard bit catches the last bit shifted out; it is 0 for a zero amount
    shl_w   = {1'b0, bus.op_a} << sh_amt;
    shr_w   = {bus.op_a, 1'b0} >> sh_amt;
    case (bus.op)
      OP_NOT: alu_res = ~bus.op_a;
      OP_INC: begin
        arith   = {1'b0, bus.op_a} + (WIDTH+1)'(1);
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
      end
      OP_DEC: begin
        arith   = {1'b0, bus.op_a} - (WIDTH+1)'(1);
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
      end
      OP_ADD: begin
        arith   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
      end
      OP_SUB: begin
        arith   = {1'b0, bus.op_a} - {1'b0, bus.op_b};
        alu_res = arith[WIDTH-1:0];
        alu_c   = arith[WIDTH];
      end
      OP_AND: alu_res = bus.op_a & bus.op_b;
      OP_OR:  alu_res = bus.op_a | bus.op_b;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  state_e           state_q, state_d;
  logic             fwe_q, fwe_d, is_md, md_start, md_done, md_carry;
  carry_sel_e       csel_q, csel_d;
  logic [WIDTH-1:0] md_result;

  assign is_md     = (bus.op == OP_MUL) || (bus.op == OP_DIV);
  assign sc_accept = accept & ~is_md;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .op_i     (bus.op),
    .a_i      (bus.op_a),
    .b_i      (bus.op_b),
    .done_o   (md_done),
    .result_o (md_result),
    .carry_o  (md_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fwe_q   <= 1'b0;
      csel_q  <= CS_ALU;
    end else begin
      state_q <= state_d;
      fwe_q   <= fwe_d;
      csel_q  <= csel_d;
    end
  end
`else
  assign sc_accept = accept;
  assign in_ready  = 1'b1;
  assign busy      = 1'b0;
`endif

  always_comb begin
    result_d    = result_q;
    out_valid_d = 1'b0;
    flags_d     = flags_q;
`ifdef ALU_SEQ_MULDIV_EN
    state_d  = state_q;
    fwe_d    = fwe_q;
    csel_d   = csel_q;
    md_start = 1'b0;
    unique case (state_q)
      IDLE: if (accept && is_md) begin
        md_start = 1'b1;
        fwe_d    = bus.flag_we;
        csel_d   = carry_sel_e'(bus.carry_sel);
        state_d  = ITER;
      end
      ITER: if (md_done) begin
        result_d    = md_result;
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (fwe_q)
          flags_d = next_flags(flags_q, csel_q, md_carry, md_result[WIDTH-1], md_result == '0);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`endif
    if (sc_accept) begin
      result_d    = alu_res;
      out_valid_d = 1'b1;
      if (bus.flag_we)
        flags_d = next_flags(flags_q, carry_sel_e'(bus.carry_sel), alu_c,
                             alu_res[WIDTH-1], alu_res == '0);
    end
    if (bus.flag_restore)
      flags_d = bus.flags_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed + random bench for alu_seq with a result/flags scoreboard.
module tb_alu_seq;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [W-1:0] res;
    logic [2:0]   fl;
  } exp_t;

  exp_t         sbq[$];
  int           total = 0;
  int           bad = 0;
  logic [2:0]   mflags;
  logic [W-1:0] last_res;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: returns {carry, result}
  function automatic logic [W:0] model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned la, lb, r, mask;
    logic c;
    logic [W-1:0] s;
    int n;
    la = 64'(a); lb = 64'(b); mask = (64'd1 << W) - 1;
    c = 1'b0; r = lb; s = a; n = int'(b[3:0]);
    case (o)
      4'd0: r = ~la;
      4'd1: begin r = la + 1; c = (a == {W{1'b1}}); end
      4'd2: begin r = la - 1; c = (a == '0); end
      4'd3: begin r = la + lb; c = ((r >> W) & 1) != 0; end
      4'd4: begin r = la - lb; c = (la < lb); end
      4'd5: r = la & lb;
      4'd6: r = la | lb;
      4'd7: begin
        for (int i = 0; i < n; i++) begin c = s[W-1]; s = s << 1; end
        r = 64'(s);
      end
      4'd8: begin
        for (int i = 0; i < n; i++) begin c = s[0]; s = s >> 1; end
        r = 64'(s);
      end
`ifdef ALU_SEQ_MULDIV_EN
      4'd9: begin r = la * lb; c = (r >> W) != 0; end
      4'd10: begin
        if (lb == 0) begin r = mask; c = 1'b1; end
        else r = la / lb;
      end
`endif
      default: r = lb;
    endcase
    r = r & mask;
    return {c, r[W-1:0]};
  endfunction

  function automatic logic [2:0] fmodel(input logic [2:0] cur, input logic [1:0] cs,
                                        input logic c, input logic [W-1:0] r);
    logic cn;
    case (cs)
      2'b00:   cn = c;
      2'b01:   cn = 1'b1;
      2'b10:   cn = 1'b0;
      default: cn = cur[2];
    endcase
    return {cn, r[W-1], r == '0};
  endfunction

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] cs, input logic fwe, input logic fr, input logic [2:0] fin);
    logic [W:0] m;
    exp_t e;
    m = model(o, a, b);
    if (fwe) mflags = fmodel(mflags, cs, m[W], m[W-1:0]);
    if (fr) mflags = fin;
    e.res = m[W-1:0];
    e.fl  = mflags;
    sbq.push_back(e);
    last_res = m[W-1:0];
    bus.op = o; bus.op_a = a; bus.op_b = b; bus.carry_sel = cs; bus.flag_we = fwe;
    bus.flag_restore = fr; bus.flags_in = fin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flag_restore = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sbq.size() != 0 && n < maxc) begin
      @(negedge clk); #1;
      n++;
    end
    check("scoreboard drained", 64'(sbq.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, " result"},    64'(bus.result),    64'd0);
    check({tag, " flags"},     64'(bus.flags),     64'd0);
    check({tag, " busy"},      64'(bus.busy),      64'd0);
    check({tag, " in_ready"},  64'(bus.in_ready),  64'd1);
  endtask

`ifdef ALU_SEQ_MULDIV_EN
  task automatic mdrun(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat = 0;
    issue(o, a, b, 2'b00, 1'b1, 1'b0, 3'b000);
    // an ADD held on the bus during the iteration must not be taken
    bus.op = 4'd3; bus.op_a = 16'd1; bus.op_b = 16'd1; bus.flag_we = 1'b1; bus.in_valid = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      check("md in_ready low", 64'(bus.in_ready), 64'd0);
      check("md busy high", 64'(bus.busy), 64'd1);
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus.in_valid = 1'b0;
    check("md latency", 64'(lat), 64'(W + 1));
    @(negedge clk);
    check("md out_valid pulse", 64'(bus.out_valid), 64'd0);
    check("md in_ready back", 64'(bus.in_ready), 64'd1);
    check("md busy clear", 64'(bus.busy), 64'd0);
  endtask
`endif

  // scoreboard consumer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          check("spurious out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          e = sbq.pop_front();
          check("sb result", 64'(bus.result), 64'(e.res));
          check("sb flags",  64'(bus.flags),  64'(e.fl));
        end
      end
    end
  end

  initial begin
    logic [3:0] ro;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.op_a = '0; bus.op_b = '0; bus.carry_sel = '0;
    bus.flag_we = 1'b0; bus.flag_restore = 1'b0; bus.flags_in = '0;
    mflags = '0; last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // ADD overflow to zero
    issue(4'd3, 16'hFFFF, 16'h0001, 2'b00, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    check("add latency", 64'(bus.out_valid), 64'd1);
    check("add result", 64'(bus.result), 64'h0000);
    check("add flags", 64'(bus.flags), 64'b101);
    @(negedge clk);
    check("out_valid one cycle", 64'(bus.out_valid), 64'd0);
    check("result holds", 64'(bus.result), 64'h0000);

    // shifts, carry_sel variants and plain ops, issued back-to-back
    issue(4'd7, 16'h8001, 16'd1, 2'b00, 1'b1, 1'b0, 3'b000);
    issue(4'd8, 16'h0001, 16'd0, 2'b00, 1'b1, 1'b0, 3'b000);
    issue(4'd8, 16'h8003, 16'd2, 2'b00, 1'b1, 1'b0, 3'b000);
    issue(4'd3, 16'h0001, 16'h0001, 2'b01, 1'b1, 1'b0, 3'b000);
    issue(4'd3, 16'hFFFF, 16'h0002, 2'b10, 1'b1, 1'b0, 3'b000);
    issue(4'd4, 16'd5, 16'd7, 2'b11, 1'b1, 1'b0, 3'b000);
    issue(4'd1, 16'hFFFF, 16'd0, 2'b00, 1'b1, 1'b0, 3'b000);
    issue(4'd2, 16'h0000, 16'd0, 2'b00, 1'b1, 1'b0, 3'b000);
    issue(4'd0, 16'h0000, 16'd0, 2'b00, 1'b0, 1'b0, 3'b000);
    issue(4'd5, 16'hF0F0, 16'h3C3C, 2'b00, 1'b1, 1'b0, 3'b000);
    issue(4'd6, 16'hF0F0, 16'h0F0F, 2'b00, 1'b1, 1'b0, 3'b000);
    issue(4'd13, 16'h1234, 16'hABCD, 2'b00, 1'b1, 1'b0, 3'b000);
    drain(5);

    // restore wins over a simultaneous ALU flag update
    issue(4'd3, 16'd1, 16'd2, 2'b00, 1'b1, 1'b1, 3'b010);
    drain(5);
    check("restore beats update", 64'(bus.flags), 64'b010);

    // standalone restore leaves result and out_valid alone
    bus.flag_restore = 1'b1; bus.flags_in = 3'b101;
    @(posedge clk); #1;
    bus.flag_restore = 1'b0;
    mflags = 3'b101;
    @(negedge clk);
    check("restore flags", 64'(bus.flags), 64'b101);
    check("restore no out_valid", 64'(bus.out_valid), 64'd0);
    check("restore result kept", 64'(bus.result), 64'(last_res));

    for (int k = 0; k < 24; k++) begin
      ro = 4'($urandom_range(0, 15));
`ifdef ALU_SEQ_MULDIV_EN
      if (ro == 4'd9 || ro == 4'd10) ro = 4'd4;
`endif
      issue(ro, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'b0, 3'b000);
    end
    drain(5);

`ifdef ALU_SEQ_MULDIV_EN
    mdrun(4'd9, 16'd300, 16'd300);
    check("mul result", 64'(bus.result), 64'h5F90);
    check("mul carry", 64'(bus.flags[2]), 64'd1);
    mdrun(4'd10, 16'd100, 16'd0);
    check("div0 result", 64'(bus.result), 64'hFFFF);
    check("div0 carry", 64'(bus.flags[2]), 64'd1);
    mdrun(4'd10, 16'd100, 16'd7);
    check("div result", 64'(bus.result), 64'd14);
    check("div carry", 64'(bus.flags[2]), 64'd0);
    mdrun(4'd9, 16'hABCD, 16'h0003);
`else
    issue(4'd9, 16'd300, 16'd300, 2'b00, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    check("op9 single cycle", 64'(bus.out_valid), 64'd1);
    check("op9 busy", 64'(bus.busy), 64'd0);
    check("op9 pass result", 64'(bus.result), 64'd300);
    issue(4'd10, 16'd100, 16'd0, 2'b00, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    check("op10 pass result", 64'(bus.result), 64'd0);
    check("op10 carry", 64'(bus.flags[2]), 64'd0);
`endif
    drain(5);

    // reset in the middle of a multiply
    issue(4'd9, 16'd300, 16'd300, 2'b00, 1'b1, 1'b0, 3'b000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    sbq.delete();
    mflags = '0;
    check_reset_outputs("async reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("post abort flags", 64'(bus.flags), 64'd0);
    issue(4'd4, 16'd3, 16'd5, 2'b00, 1'b1, 1'b0, 3'b000);
    @(negedge clk);
    check("sub after abort result", 64'(bus.result), 64'hFFFE);
    check("sub after abort flags", 64'(bus.flags), 64'b110);

    drain(50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
